// File: rtl/rram_write_verify_ctrl_if.sv
// Request/response handshake bundle between the array sequencer (master)
// and the RRAM write-verify controller (slave).
interface rram_write_verify_ctrl_if;
  logic req_valid;
  logic req_ready;
  logic req_op;
  logic rsp_valid;
  logic rsp_ready;
  logic rsp_ok;

  modport master (
    output req_valid, req_op, rsp_ready,
    input  req_ready, rsp_valid, rsp_ok
  );

  modport slave (
    input  req_valid, req_op, rsp_ready,
    output req_ready, rsp_valid, rsp_ok
  );
endinterface

// File: rtl/rram_write_verify_ctrl.sv
// Write-verify controller for one RRAM cell: ramped SET/RESET pulses with a verify read after each.
// Optional macro RRAM_WV_PULSE_CNT_EN exports the per-request pulse count as rsp_pulses.
module rram_write_verify_ctrl #(
  parameter int unsigned DAC_W      = 6,
  parameter int unsigned PULSE_CYC  = 10,
  parameter int unsigned SETTLE_CYC = 4,
  parameter int unsigned READ_CYC   = 2,
  parameter int unsigned MAX_PULSES = 8,
  parameter int unsigned VSTART_SET = 20,
  parameter int unsigned VSTART_RST = 24,
  parameter int unsigned VSTEP      = 3,
  parameter int unsigned VMAX       = 40
) (
  input  logic                    clk,
  input  logic                    rst,
  rram_write_verify_ctrl_if.slave bus,
  output logic                    set_pulse,
  output logic                    reset_pulse,
  output logic [DAC_W-1:0]        vamp,
  output logic                    read_en,
  input  logic                    sense_lrs
`ifdef RRAM_WV_PULSE_CNT_EN
  ,
  output logic [$clog2(MAX_PULSES+1)-1:0] rsp_pulses
`endif
);
  localparam int unsigned CW   = $clog2(MAX_PULSES + 1);
  localparam int unsigned TMAX = (PULSE_CYC > SETTLE_CYC)
                               ? ((PULSE_CYC > READ_CYC) ? PULSE_CYC : READ_CYC)
                               : ((SETTLE_CYC > READ_CYC) ? SETTLE_CYC : READ_CYC);
  localparam int unsigned TW   = $clog2(TMAX + 1);

  localparam logic [TW-1:0]    PULSE_LAST  = TW'(PULSE_CYC - 1);
  localparam logic [TW-1:0]    SETTLE_LAST = TW'(SETTLE_CYC - 1);
  localparam logic [TW-1:0]    READ_LAST   = TW'(READ_CYC - 1);
  localparam logic [CW-1:0]    CNT_MAX     = CW'(MAX_PULSES);
  localparam logic [DAC_W-1:0] AMP_SET     = DAC_W'(VSTART_SET);
  localparam logic [DAC_W-1:0] AMP_RST     = DAC_W'(VSTART_RST);
  localparam logic [DAC_W:0]   STEP_W      = (DAC_W + 1)'(VSTEP);
  localparam logic [DAC_W:0]   VMAX_W      = (DAC_W + 1)'(VMAX);

  typedef enum logic [2:0] {IDLE, READ, PULSE, SETTLE, DONE} state_t;

  state_t           state, state_n;
  logic [TW-1:0]    timer, timer_n;
  logic [DAC_W-1:0] amp, amp_n;
  logic [CW-1:0]    cnt, cnt_n;
  logic             op, op_n;
  logic             ok, ok_n;
  logic             ready, rsp_v, rsp_ok_r;
  logic [DAC_W:0]   amp_sum;
  logic             hit;

  assign bus.req_ready = ready;
  assign bus.rsp_valid = rsp_v;
  assign bus.rsp_ok    = rsp_ok_r;
`ifdef RRAM_WV_PULSE_CNT_EN
  assign rsp_pulses    = cnt;
`endif

  always_comb begin
    state_n = state;
    timer_n = timer;
    amp_n   = amp;
    cnt_n   = cnt;
    op_n    = op;
    ok_n    = ok;
    amp_sum = {1'b0, amp} + STEP_W;
    hit     = op ? sense_lrs : !sense_lrs;
    case (state)
      IDLE: begin
        if (bus.req_valid && ready) begin
          op_n    = bus.req_op;
          amp_n   = bus.req_op ? AMP_SET : AMP_RST;
          cnt_n   = '0;
          timer_n = '0;
          ok_n    = 1'b0;
          state_n = READ;
        end
      end
      READ: begin
        if (timer == READ_LAST) begin
          timer_n = '0;
          // A hit on the final verify read still counts as success.
          if (hit) begin
            ok_n    = 1'b1;
            state_n = DONE;
          end else if (cnt == CNT_MAX) begin
            ok_n    = 1'b0;
            state_n = DONE;
          end else begin
            state_n = PULSE;
          end
        end else begin
          timer_n = timer + 1'b1;
        end
      end
      PULSE: begin
        if (timer == PULSE_LAST) begin
          timer_n = '0;
          cnt_n   = cnt + 1'b1;
          amp_n   = (amp_sum > VMAX_W) ? VMAX_W[DAC_W-1:0] : amp_sum[DAC_W-1:0];
          state_n = SETTLE;
        end else begin
          timer_n = timer + 1'b1;
        end
      end
      SETTLE: begin
        if (timer == SETTLE_LAST) begin
          timer_n = '0;
          state_n = READ;
        end else begin
          timer_n = timer + 1'b1;
        end
      end
      DONE: begin
        if (bus.rsp_ready && rsp_v) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // Outputs are registered from the next-state decode so they align with the state they describe.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      timer       <= '0;
      amp         <= '0;
      cnt         <= '0;
      op          <= 1'b0;
      ok          <= 1'b0;
      ready       <= 1'b0;
      rsp_v       <= 1'b0;
      rsp_ok_r    <= 1'b0;
      set_pulse   <= 1'b0;
      reset_pulse <= 1'b0;
      vamp        <= '0;
      read_en     <= 1'b0;
    end else begin
      state       <= state_n;
      timer       <= timer_n;
      amp         <= amp_n;
      cnt         <= cnt_n;
      op          <= op_n;
      ok          <= ok_n;
      ready       <= (state_n == IDLE);
      rsp_v       <= (state_n == DONE);
      rsp_ok_r    <= (state_n == DONE) && ok_n;
      set_pulse   <= (state_n == PULSE) && op_n;
      reset_pulse <= (state_n == PULSE) && !op_n;
      vamp        <= (state_n == PULSE) ? amp_n : '0;
      read_en     <= (state_n == READ);
    end
  end
endmodule

// File: tb/tb_rram_write_verify_ctrl.sv
// Directed, table-driven bench for rram_write_verify_ctrl with a behavioural cell model on sense_lrs.
// Builds with or without RRAM_WV_PULSE_CNT_EN.
module tb_rram_write_verify_ctrl;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       set_pulse, reset_pulse, read_en;
  logic       sense_lrs = 1'b0;
  logic [5:0] vamp;
`ifdef RRAM_WV_PULSE_CNT_EN
  logic [3:0] rsp_pulses;
`endif

  rram_write_verify_ctrl_if bus();

  rram_write_verify_ctrl #(
    .DAC_W(6), .PULSE_CYC(10), .SETTLE_CYC(4), .READ_CYC(2), .MAX_PULSES(8),
    .VSTART_SET(20), .VSTART_RST(24), .VSTEP(3), .VMAX(40)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus),
    .set_pulse(set_pulse),
    .reset_pulse(reset_pulse),
    .vamp(vamp),
    .read_en(read_en),
    .sense_lrs(sense_lrs)
`ifdef RRAM_WV_PULSE_CNT_EN
    ,
    .rsp_pulses(rsp_pulses)
`endif
  );

  always #5 clk = ~clk;

  int   n_cmp = 0;
  int   n_err = 0;
  int   pulses_seen = 0;
  int   run_len = 0;
  int   gap = 0;
  bit   prev_gate = 1'b0;
  bit   in_gap = 1'b0;
  bit   rand_sense = 1'b0;
  logic cur_op = 1'b0;
  int   cur_flip = 0;
  int   amp_log [16];

  typedef struct {
    logic op;
    int   flip;        // pulses after which the cell reaches target (99 = never)
    logic exp_ok;
    int   exp_pulses;
    int   exp_first;
    int   exp_last;
  } vec_t;
  vec_t vecs [8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic update_sense();
    if (rand_sense) sense_lrs = 1'($urandom_range(0, 1));
    else            sense_lrs = (pulses_seen >= cur_flip) ? cur_op : !cur_op;
  endtask

  task automatic clear_monitor();
    prev_gate = 1'b0;
    in_gap    = 1'b0;
    run_len   = 0;
    gap       = 0;
  endtask

  // One clock; sample 1 time unit after the rising edge, check invariants and track pulses.
  task automatic step();
    bit gate;
    @(posedge clk);
    #1;
    gate = set_pulse | reset_pulse;
    check("inv_both_gates", set_pulse & reset_pulse, 0);
    check("inv_read_with_gate", read_en & gate, 0);
    check("inv_ready_with_rsp", bus.req_ready & bus.rsp_valid, 0);
    check("vamp_le_vmax", vamp > 6'd40, 0);
    if (!gate) check("vamp_zero_no_gate", vamp, 0);
    if (in_gap) begin
      if (read_en) begin
        check("settle_gap", gap, 4);
        in_gap = 1'b0;
      end else begin
        gap++;
      end
    end
    if (gate && !prev_gate) begin
      pulses_seen++;
      if (pulses_seen <= 16) amp_log[pulses_seen-1] = vamp;
      run_len = 1;
      check("gate_select", set_pulse, cur_op);
    end else if (gate) begin
      run_len++;
      if (pulses_seen >= 1 && pulses_seen <= 16) check("vamp_const", vamp, amp_log[pulses_seen-1]);
    end
    if (!gate && prev_gate) begin
      check("pulse_len", run_len, 10);
      gap    = 1;
      in_gap = 1'b1;
    end
    prev_gate = gate;
    update_sense();
  endtask

  task automatic start_req(input logic op, input int flip);
    cur_op      = op;
    cur_flip    = flip;
    pulses_seen = 0;
    for (int i = 0; i < 16; i++) amp_log[i] = 0;
    update_sense();
    for (int i = 0; i < 20 && !bus.req_ready; i++) step();
    check("ready_before_req", bus.req_ready, 1);
    bus.req_valid = 1'b1;
    bus.req_op    = op;
    step();
    bus.req_valid = 1'b0;
    check("ready_drop_on_accept", bus.req_ready, 0);
  endtask

  task automatic wait_rsp();
    int t;
    t = 0;
    while (!bus.rsp_valid && t < 400) begin
      step();
      t++;
    end
    check("rsp_valid_in_budget", bus.rsp_valid, 1);
  endtask

  task automatic take_rsp();
    bus.rsp_ready = 1'b1;
    step();
    bus.rsp_ready = 1'b0;
    check("rsp_valid_drop", bus.rsp_valid, 0);
    check("ready_after_rsp", bus.req_ready, 1);
  endtask

  task automatic run_req(input logic op, input int flip, output logic ok, output int np);
    start_req(op, flip);
    wait_rsp();
    ok = bus.rsp_ok;
    np = pulses_seen;
`ifdef RRAM_WV_PULSE_CNT_EN
    check("rsp_pulses", rsp_pulses, np);
`endif
    take_rsp();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, got running expected finished");
    $fatal(1, "watchdog");
  end

  initial begin
    logic ok;
    int   np;
    int   exp_rst [8];
    int   exp_set [3];

    vecs[0] = '{1'b1,  0, 1'b1, 0,  0,  0};
    vecs[1] = '{1'b1,  3, 1'b1, 3, 20, 26};
    vecs[2] = '{1'b0, 99, 1'b0, 8, 24, 40};
    vecs[3] = '{1'b0,  0, 1'b1, 0,  0,  0};
    vecs[4] = '{1'b0,  1, 1'b1, 1, 24, 24};
    vecs[5] = '{1'b1,  8, 1'b1, 8, 20, 40};
    vecs[6] = '{1'b1, 99, 1'b0, 8, 20, 40};
    vecs[7] = '{1'b0,  7, 1'b1, 7, 24, 40};
    exp_rst = '{24, 27, 30, 33, 36, 39, 40, 40};
    exp_set = '{20, 23, 26};

    bus.req_valid = 1'b0;
    bus.req_op    = 1'b0;
    bus.rsp_ready = 1'b0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_req_ready", bus.req_ready, 0);
    check("rst_rsp_valid", bus.rsp_valid, 0);
    check("rst_rsp_ok", bus.rsp_ok, 0);
    check("rst_set_pulse", set_pulse, 0);
    check("rst_reset_pulse", reset_pulse, 0);
    check("rst_vamp", vamp, 0);
    check("rst_read_en", read_en, 0);
`ifdef RRAM_WV_PULSE_CNT_EN
    check("rst_rsp_pulses", rsp_pulses, 0);
`endif
    rst = 1'b0;
    #1;
    check("ready_low_before_edge", bus.req_ready, 0);
    step();
    check("ready_first_edge", bus.req_ready, 1);

    // Already-at-target latency: read_en cycles 1-2, rsp_valid cycle 3
    cur_op = 1'b1; cur_flip = 0; pulses_seen = 0; update_sense();
    bus.req_valid = 1'b1;
    bus.req_op    = 1'b1;
    step();
    bus.req_valid = 1'b0;
    check("lat_c1_read_en", read_en, 1);
    check("lat_c1_rsp_valid", bus.rsp_valid, 0);
    step();
    check("lat_c2_read_en", read_en, 1);
    check("lat_c2_rsp_valid", bus.rsp_valid, 0);
    step();
    check("lat_c3_read_en", read_en, 0);
    check("lat_c3_rsp_valid", bus.rsp_valid, 1);
    check("lat_c3_rsp_ok", bus.rsp_ok, 1);
    check("lat_no_pulse", pulses_seen, 0);
    take_rsp();

    // Table-driven requests
    for (int v = 0; v < 8; v++) begin
      run_req(vecs[v].op, vecs[v].flip, ok, np);
      check($sformatf("vec%0d_ok", v), ok, vecs[v].exp_ok);
      check($sformatf("vec%0d_pulses", v), np, vecs[v].exp_pulses);
      if (vecs[v].exp_pulses > 0) begin
        check($sformatf("vec%0d_first_amp", v), amp_log[0], vecs[v].exp_first);
        check($sformatf("vec%0d_last_amp", v), amp_log[vecs[v].exp_pulses-1], vecs[v].exp_last);
      end
    end

    // Full amplitude ramps
    run_req(1'b0, 99, ok, np);
    for (int i = 0; i < 8; i++) check($sformatf("rst_ramp%0d", i), amp_log[i], exp_rst[i]);
    run_req(1'b1, 3, ok, np);
    for (int i = 0; i < 3; i++) check($sformatf("set_ramp%0d", i), amp_log[i], exp_set[i]);

    // Response back-pressure with a stray request in the window
    start_req(1'b1, 0);
    wait_rsp();
    for (int i = 0; i < 10; i++) begin
      bus.req_valid = (i == 4);
      bus.req_op    = 1'b0;
      step();
      check("bp_rsp_valid", bus.rsp_valid, 1);
      check("bp_rsp_ok", bus.rsp_ok, 1);
      check("bp_req_ready", bus.req_ready, 0);
    end
    bus.req_valid = 1'b0;
    take_rsp();
    repeat (3) begin
      step();
      check("stray_req_ignored", read_en, 0);
      check("stray_ready_held", bus.req_ready, 1);
    end

    // Asynchronous reset during pulse 5
    start_req(1'b1, 99);
    for (int i = 0; i < 200 && pulses_seen < 5; i++) step();
    check("reached_pulse5", pulses_seen, 5);
    step();
    step();
    check("mid_pulse_gate", set_pulse, 1);
    rst = 1'b1;
    #1;
    check("async_set_pulse", set_pulse, 0);
    check("async_vamp", vamp, 0);
    check("async_read_en", read_en, 0);
    check("async_rsp_valid", bus.rsp_valid, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    clear_monitor();
    step();
    check("ready_after_rst", bus.req_ready, 1);
    run_req(1'b1, 2, ok, np);
    check("post_rst_ok", ok, 1);
    check("post_rst_pulses", np, 2);
    check("post_rst_amp0", amp_log[0], 20);
    check("post_rst_amp1", amp_log[1], 23);

    // Random op / sense
    rand_sense = 1'b1;
    for (int r = 0; r < 300; r++) begin
      run_req(1'($urandom_range(0, 1)), 0, ok, np);
      check("rand_budget", np <= 8, 1);
      if (!ok) check("rand_exhausted", np, 8);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
